// File: rtl/shift_stage16_pkg.sv
// shift_stage16_pkg: shared widths, op codes and request record for the shift stage.
package shift_stage16_pkg;
    localparam int DW = 16;
    localparam int SW = 4;
    typedef enum logic [1:0] {OP_SLL = 2'b00, OP_SRL = 2'b01, OP_SRA = 2'b10, OP_ROR = 2'b11} op_e;
    typedef struct packed {
        logic [DW-1:0] a;
        logic [SW-1:0] shr;
        op_e           op;
    } req_t;
endpackage

// File: rtl/shift_stage16_if.sv
// shift_stage16_if: request/result handshake bundle of the shift stage.
interface shift_stage16_if import shift_stage16_pkg::*; ;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a;
    logic [SW-1:0] in_shr;
    op_e           in_op;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_ovf;
    logic          out_err;
    logic [1:0]    occupancy;
    modport master (
        output in_valid, in_a, in_shr, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, out_err, occupancy
    );
    modport slave (
        input  in_valid, in_a, in_shr, in_op, out_ready,
        output in_ready, out_valid, out_data, out_ovf, out_err, occupancy
    );
endinterface

// File: rtl/shift_req_fifo2.sv
// shift_req_fifo2: two-entry request queue; ready depends only on fill level.
module shift_req_fifo2 import shift_stage16_pkg::*; (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_valid,
    output logic       push_ready,
    input  req_t       push_data,
    input  logic       pop,
    output req_t       head,
    output logic       head_valid,
    output logic [1:0] count
);
    req_t mem [2];
    logic wp, rp, push;
    assign push_ready = count != 2'd2;
    assign push = push_valid && push_ready;
    assign head = mem[rp];
    assign head_valid = count != 2'd0;
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= 1'b0;
            rp <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= push_data;
                wp <= ~wp;
            end
            if (pop) rp <= ~rp;
            count <= count + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: rtl/shift_stage16.sv
// shift_stage16: queued 16-bit shifter with registered result; op 11 rotates only
// when SHIFT_STAGE16_ROR_EN is defined, otherwise it passes through flagged as an error.
module shift_stage16 import shift_stage16_pkg::*; (
    input logic           clk,
    input logic           rst,
    shift_stage16_if.slave bus
);
    req_t            in_req, head;
    logic            head_valid, pop;
    logic [2*DW-1:0] sll_w;
    logic [DW-1:0]   sra_res, ror_res, res;
    logic            ovf, err;
    assign in_req = '{a: bus.in_a, shr: bus.in_shr, op: bus.in_op};
    assign pop = head_valid && (!bus.out_valid || bus.out_ready);
    shift_req_fifo2 u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (bus.in_valid),
        .push_ready (bus.in_ready),
        .push_data  (in_req),
        .pop        (pop),
        .head       (head),
        .head_valid (head_valid),
        .count      (bus.occupancy)
    );
    // upper half of the widened SLL holds exactly the bits shifted out
    assign sll_w = {{DW{1'b0}}, head.a} << head.shr;
    assign sra_res = $signed(head.a) >>> head.shr;
`ifdef SHIFT_STAGE16_ROR_EN
    localparam logic ROR_ERR = 1'b0;
    assign ror_res = DW'({head.a, head.a} >> head.shr);
`else
    localparam logic ROR_ERR = 1'b1;
    assign ror_res = head.a;
`endif
    always_comb begin
        res = head.op == OP_SLL ? sll_w[DW-1:0] :
              head.op == OP_SRL ? head.a >> head.shr :
              head.op == OP_SRA ? sra_res : ror_res;
        ovf = head.op == OP_SLL && |sll_w[2*DW-1:DW];
        err = head.op == OP_ROR && ROR_ERR;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data <= '0;
            bus.out_ovf <= 1'b0;
            bus.out_err <= 1'b0;
        end else if (pop) begin
            bus.out_valid <= 1'b1;
            bus.out_data <= res;
            bus.out_ovf <= ovf;
            bus.out_err <= err;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_shift_stage16.sv
// tb_shift_stage16: directed checks of the shift stage with hand-computed results.
module tb_shift_stage16;
    import shift_stage16_pkg::*;
    logic clk = 1'b0;
    logic rst;
    int n_cmp = 0;
    int n_err = 0;
    shift_stage16_if bus ();
    shift_stage16 dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
`ifdef SHIFT_STAGE16_ROR_EN
    localparam logic [15:0] ROR_DATA = 16'h8000;
    localparam logic [15:0] ROR_ERR = 16'h0000;
`else
    localparam logic [15:0] ROR_DATA = 16'h0001;
    localparam logic [15:0] ROR_ERR = 16'h0001;
`endif
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic drive(input logic [15:0] a, input logic [3:0] s, input op_e op);
        bus.in_valid = 1'b1;
        bus.in_a = a;
        bus.in_shr = s;
        bus.in_op = op;
    endtask
    task automatic push(input logic [15:0] a, input logic [3:0] s, input op_e op);
        drive(a, s, op);
        tick();
        bus.in_valid = 1'b0;
    endtask
    task automatic result(input string tag, input logic [15:0] d, input logic ovf, input logic err);
        chk({tag, "_valid"}, 16'(bus.out_valid), 16'h1);
        chk({tag, "_data"}, bus.out_data, d);
        chk({tag, "_ovf"}, 16'(bus.out_ovf), 16'(ovf));
        chk({tag, "_err"}, 16'(bus.out_err), 16'(err));
    endtask
    task automatic one(input string tag, input logic [15:0] a, input logic [3:0] s, input op_e op,
                       input logic [15:0] d, input logic ovf, input logic err);
        push(a, s, op);
        tick();
        result(tag, d, ovf, err);
        tick();
    endtask
    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_shr = '0;
        bus.in_op = OP_SLL;
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("rst_valid", 16'(bus.out_valid), 16'h0);
        chk("rst_data", bus.out_data, 16'h0);
        chk("rst_ovf", 16'(bus.out_ovf), 16'h0);
        chk("rst_err", 16'(bus.out_err), 16'h0);
        chk("rst_occ", 16'(bus.occupancy), 16'h0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 16'(bus.in_ready), 16'h1);
        // latency: queued after first edge, visible after second
        push(16'h8001, 4'd1, OP_SLL);
        chk("lat_occ", 16'(bus.occupancy), 16'h1);
        chk("lat_valid0", 16'(bus.out_valid), 16'h0);
        tick();
        result("sll1", 16'h0002, 1'b1, 1'b0);
        tick();
        chk("sll1_drained", 16'(bus.out_valid), 16'h0);
        // back-to-back throughput
        drive(16'h8000, 4'd4, OP_SRA);
        tick();
        drive(16'h8000, 4'd4, OP_SRL);
        tick();
        bus.in_valid = 1'b0;
        result("b2b_sra", 16'hF800, 1'b0, 1'b0);
        tick();
        result("b2b_srl", 16'h0800, 1'b0, 1'b0);
        tick();
        chk("b2b_drained", 16'(bus.out_valid), 16'h0);
        one("sll_noovf", 16'h0234, 4'd4, OP_SLL, 16'h2340, 1'b0, 1'b0);
        one("sll15", 16'h0003, 4'd15, OP_SLL, 16'h8000, 1'b1, 1'b0);
        one("srl15", 16'hFFFF, 4'd15, OP_SRL, 16'h0001, 1'b0, 1'b0);
        one("sra15_pos", 16'h7FFF, 4'd15, OP_SRA, 16'h0000, 1'b0, 1'b0);
        one("sra15_neg", 16'h8000, 4'd15, OP_SRA, 16'hFFFF, 1'b0, 1'b0);
        one("ror1", 16'h0001, 4'd1, OP_ROR, ROR_DATA, 1'b0, ROR_ERR[0]);
        for (int i = 0; i < 3; i++)
            one("shr0", 16'hABCD, 4'd0, op_e'(i), 16'hABCD, 1'b0, 1'b0);
        one("shr0_ror", 16'hABCD, 4'd0, OP_ROR, 16'hABCD, 1'b0, ROR_ERR[0]);
        // backpressure: 3 of 4 accepted, output frozen
        bus.out_ready = 1'b0;
        drive(16'h0001, 4'd1, OP_SLL);
        tick();
        drive(16'h0010, 4'd1, OP_SRL);
        tick();
        drive(16'h0100, 4'd4, OP_SLL);
        tick();
        drive(16'h1000, 4'd1, OP_SRL);
        tick();
        chk("bp_ready", 16'(bus.in_ready), 16'h0);
        chk("bp_occ", 16'(bus.occupancy), 16'h2);
        result("bp_hold", 16'h0002, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        tick();
        result("bp_hold2", 16'h0002, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        tick();
        result("bp_drain2", 16'h0008, 1'b0, 1'b0);
        chk("bp_occ1", 16'(bus.occupancy), 16'h1);
        tick();
        result("bp_drain3", 16'h1000, 1'b0, 1'b0);
        chk("bp_occ0", 16'(bus.occupancy), 16'h0);
        tick();
        chk("bp_no4th", 16'(bus.out_valid), 16'h0);
        // reset while full and holding a result
        bus.out_ready = 1'b0;
        drive(16'h0001, 4'd1, OP_SLL);
        tick();
        drive(16'h0002, 4'd1, OP_SLL);
        tick();
        drive(16'h0003, 4'd1, OP_SLL);
        tick();
        chk("pre_rst_occ", 16'(bus.occupancy), 16'h2);
        chk("pre_rst_valid", 16'(bus.out_valid), 16'h1);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        chk("mid_rst_valid", 16'(bus.out_valid), 16'h0);
        chk("mid_rst_occ", 16'(bus.occupancy), 16'h0);
        chk("mid_rst_ready", 16'(bus.in_ready), 16'h1);
        chk("mid_rst_data", bus.out_data, 16'h0);
        tick();
        chk("after_rst_valid1", 16'(bus.out_valid), 16'h0);
        tick();
        chk("after_rst_valid2", 16'(bus.out_valid), 16'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
